gpio_bus_arbiter: RTL and testbench
===================================

# gpio_bus_arbiter

Round-robin arbiter that shares the single GPIO register slave port between `NUM_MASTERS` bus requesters (core data bus, debug module, etc.) using the req/gnt/rvalid protocol. Sits between the peripheral interconnect and the GPIO offset decoder/register file. Allows at most one outstanding transaction and routes the response back to the owning master. Optionally recovers from a non-granting or non-responding slave with an error response.

## Interface
- `NUM_MASTERS`, 2, number of requesters (2..8)
- `TIMEOUT_CYCLES`, 16, stall limit used only when `GPIO_ARB_TIMEOUT_EN` is defined (1..255)
- `clk`  in  1  single clock, all logic on posedge
- `rst_n`  in  1  asynchronous active-low reset
- `m_req`  in  NUM_MASTERS  per-master request
- `m_we`  in  NUM_MASTERS  per-master write enable
- `m_be`  in  NUM_MASTERS×4  per-master byte enables
- `m_addr`  in  NUM_MASTERS×32  per-master address
- `m_wdata`  in  NUM_MASTERS×32  per-master write data
- `m_gnt`  out  NUM_MASTERS  one-hot grant
- `m_rvalid`  out  NUM_MASTERS  one-hot response valid
- `m_err`  out  NUM_MASTERS  response error, qualified by `m_rvalid`
- `m_rdata`  out  32  shared read data, qualified by `m_rvalid`
- `s_req`, `s_we`, `s_be[3:0]`, `s_addr[31:0]`, `s_wdata[31:0]`  out  slave request channel
- `s_gnt`  in  1  slave grant (combinational from `s_req`/`s_addr`)
- `s_rvalid`  in  1  slave response, one cycle after `s_gnt`
- `s_rdata`  in  32  slave read data

## Operation
- States: IDLE, WAIT_RSP, ERR_RSP. Registers: `owner` (index), `rr_ptr` (last granted index), `tmo_cnt`.
- Winner: first requesting master scanning from `rr_ptr+1` modulo `NUM_MASTERS`; purely combinational from `m_req` and `rr_ptr`.
- Arbitration open when state is IDLE, or WAIT_RSP with `s_rvalid`=1 (back-to-back). When open and any `m_req`: `s_req`=1, slave channel muxed from winner. Otherwise `s_req`=0, slave channel outputs driven 0.
- `s_gnt`=1 while open: `m_gnt[winner]`=1 same cycle; `owner`<=winner, `rr_ptr`<=winner, state<=WAIT_RSP.
- `s_gnt`=0: no `m_gnt`, `rr_ptr` unchanged; re-arbitrate next cycle (a new higher-priority request may win; masters keep `req` asserted per protocol).
- WAIT_RSP with `s_rvalid`: `m_rvalid[owner]`=1, `m_rdata`=`s_rdata`, `m_err`=0; state<=IDLE unless a new grant occurs the same cycle.
- `m_rdata`=0 whenever no `m_rvalid` bit is set.
- `s_rvalid` in IDLE is ignored (protocol violation; no output effect).

## Timing
- Reset: state IDLE, `owner`=0, `rr_ptr`=NUM_MASTERS-1 (master 0 wins first), `tmo_cnt`=0; all outputs 0.
- Request-to-grant: 0 cycles (combinational through arbiter and slave). Grant-to-rvalid: 1 cycle with GPIO slave.
- Throughput: one transaction per cycle when requests are continuous.
- Reset mid-transaction: state returns to IDLE immediately; pending response dropped, no `m_rvalid`.

## Configuration
- `GPIO_ARB_TIMEOUT_EN` defined: `tmo_cnt` increments each cycle in WAIT_RSP without `s_rvalid`, or in IDLE with a request present and `s_gnt`=0 (cleared on any grant, `s_rvalid`, or no request). On reaching `TIMEOUT_CYCLES`: in IDLE, arbiter asserts `m_gnt[winner]` itself (`s_req`=0 that cycle), `owner`/`rr_ptr`<=winner, state<=ERR_RSP; in WAIT_RSP, state<=ERR_RSP. ERR_RSP: one cycle `m_rvalid[owner]`=1, `m_err[owner]`=1, `m_rdata`=32'hDEAD_BEEF, state<=IDLE, counter cleared. Late `s_rvalid` after timeout is ignored.
- Not defined: no counter, ERR_RSP unreachable, `m_err` tied 0; unmapped address stalls the master indefinitely.

## Test plan
- Single read: master 0 reads GPIO_ODR (slave returns 32'h0000_00A5) -> `m_gnt[0]` same cycle, `m_rvalid[0]`+rdata 32'hA5 next cycle.
- Contention: masters 0 and 1 request continuously from reset -> grants alternate 0,1,0,1 on consecutive cycles; each rvalid one cycle after its grant.
- Slave stall: `s_gnt` held 0 for 3 cycles with master 1 requesting -> no `m_gnt`; grant on cycle 4, `rr_ptr` only then moves to 1.
- Reset during WAIT_RSP: `rst_n` low after grant -> no `m_rvalid`; after release master 0 wins first.
- Timeout (macro on, TIMEOUT_CYCLES=4): unmapped address 0xFFC, `s_gnt`=0 -> `m_gnt` after 4 cycles, `m_rvalid`+`m_err`=1, rdata 32'hDEADBEEF next cycle.
- Macro off, same stimulus -> no grant for 100 cycles, `m_err` never asserted.

Source files
------------

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing the single GPIO register slave port between NUM_MASTERS requesters.
// Optional feature macro: GPIO_ARB_TIMEOUT_EN (stall timeout with error response).
module gpio_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_MASTERS-1:0]      m_req,
    input  logic [NUM_MASTERS-1:0]      m_we,
    input  logic [NUM_MASTERS*4-1:0]    m_be,
    input  logic [NUM_MASTERS*32-1:0]   m_addr,
    input  logic [NUM_MASTERS*32-1:0]   m_wdata,
    output logic [NUM_MASTERS-1:0]      m_gnt,
    output logic [NUM_MASTERS-1:0]      m_rvalid,
    output logic [NUM_MASTERS-1:0]      m_err,
    output logic [31:0]                 m_rdata,
    output logic                        s_req,
    output logic                        s_we,
    output logic [3:0]                  s_be,
    output logic [31:0]                 s_addr,
    output logic [31:0]                 s_wdata,
    input  logic                        s_gnt,
    input  logic                        s_rvalid,
    input  logic [31:0]                 s_rdata
);

    localparam int          IW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RSP = 2'd1,
        ERR_RSP  = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [IW-1:0]          owner_r;
    logic [IW-1:0]          rr_ptr_r;
    logic [IW-1:0]          winner_s;
    logic [NUM_MASTERS-1:0] winner_oh_s;
    logic [NUM_MASTERS-1:0] owner_oh_s;
    logic                   any_req_s;
    logic                   rsp_s;
    logic                   open_s;
    logic                   force_gnt_s;
    logic                   grant_s;
    logic                   tmo_hit_s;
    logic                   sel_we_s;
    logic [3:0]             sel_be_s;
    logic [31:0]            sel_addr_s;
    logic [31:0]            sel_wdata_s;

    // Round-robin pick: smallest distance from the master after rr_ptr wins
    always_comb begin
        int  best_d;
        int  d;
        logic take;
        best_d   = NUM_MASTERS;
        d        = 0;
        take     = 1'b0;
        winner_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            d        = (i + NUM_MASTERS - 1 - int'(rr_ptr_r)) % NUM_MASTERS;
            take     = m_req[i] && (d < best_d);
            best_d   = take ? d : best_d;
            winner_s = take ? IW'(i) : winner_s;
        end
    end

    // Index-to-one-hot decode and AND-OR mux of the winning master's request channel
    always_comb begin
        winner_oh_s = '0;
        owner_oh_s  = '0;
        sel_we_s    = 1'b0;
        sel_be_s    = 4'h0;
        sel_addr_s  = 32'h0;
        sel_wdata_s = 32'h0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            winner_oh_s[i] = (winner_s == IW'(i));
            owner_oh_s[i]  = (owner_r == IW'(i));
            sel_we_s       = sel_we_s | (m_we[i] & winner_oh_s[i]);
            sel_be_s       = sel_be_s | (m_be[i*4 +: 4] & {4{winner_oh_s[i]}});
            sel_addr_s     = sel_addr_s | (m_addr[i*32 +: 32] & {32{winner_oh_s[i]}});
            sel_wdata_s    = sel_wdata_s | (m_wdata[i*32 +: 32] & {32{winner_oh_s[i]}});
        end
    end

    // Slave channel, grant/response routing and next-state decode
    always_comb begin
        any_req_s   = |m_req;
        rsp_s       = (state_r == WAIT_RSP) && s_rvalid;
        open_s      = (state_r == IDLE) || rsp_s;
        force_gnt_s = (state_r == IDLE) && any_req_s && tmo_hit_s;
        s_req       = open_s && any_req_s && !force_gnt_s;
        grant_s     = (s_req && s_gnt) || force_gnt_s;
        s_we        = s_req & sel_we_s;
        s_be        = s_req ? sel_be_s : 4'h0;
        s_addr      = s_req ? sel_addr_s : 32'h0;
        s_wdata     = s_req ? sel_wdata_s : 32'h0;
        m_gnt       = grant_s ? winner_oh_s : '0;
        m_rvalid    = '0;
        m_err       = '0;
        m_rdata     = 32'h0;
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (force_gnt_s) begin
                    state_nxt_s = ERR_RSP;
                end else if (grant_s) begin
                    state_nxt_s = WAIT_RSP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_RSP: begin
                if (s_rvalid) begin
                    m_rvalid    = owner_oh_s;
                    m_rdata     = s_rdata;
                    state_nxt_s = grant_s ? WAIT_RSP : IDLE;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ERR_RSP;
                end else begin
                    state_nxt_s = WAIT_RSP;
                end
            end
            ERR_RSP: begin
                m_rvalid    = owner_oh_s;
`ifdef GPIO_ARB_TIMEOUT_EN
                m_err       = owner_oh_s;
`endif
                m_rdata     = ERR_RDATA;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, transaction owner and round-robin pointer; pointer moves only on an actual grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            owner_r  <= '0;
            rr_ptr_r <= IW'(NUM_MASTERS - 1);
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                owner_r  <= winner_s;
                rr_ptr_r <= winner_s;
            end
        end
    end

`ifdef GPIO_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_r;
    logic [7:0] tmo_cnt_nxt_s;

    assign tmo_hit_s = (tmo_cnt_r == 8'(TIMEOUT_CYCLES));

    // Stall counter: counts ungranted IDLE requests and unanswered WAIT_RSP cycles
    always_comb begin
        tmo_cnt_nxt_s = 8'h00;
        case (state_r)
            IDLE:     tmo_cnt_nxt_s = (any_req_s && !grant_s) ? (tmo_cnt_r + 8'h01) : 8'h00;
            WAIT_RSP: tmo_cnt_nxt_s = (s_rvalid || tmo_hit_s) ? 8'h00 : (tmo_cnt_r + 8'h01);
            default:  tmo_cnt_nxt_s = 8'h00;
        endcase
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= 8'h00;
        end else begin
            tmo_cnt_r <= tmo_cnt_nxt_s;
        end
    end
`else
    // Without the timeout a non-granting slave stalls the master indefinitely
    logic unused_tmo_s;
    assign tmo_hit_s    = 1'b0;
    assign unused_tmo_s = ^8'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Self-checking bench for gpio_bus_arbiter: directed protocol cases plus randomized traffic
// checked every cycle against a transaction-level round-robin model.
module tb_gpio_bus_arbiter;

    localparam int N   = 3;
    localparam int TMO = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              slv_rst_n;
    logic [N-1:0]      m_req;
    logic [N-1:0]      m_we;
    logic [N*4-1:0]    m_be;
    logic [N*32-1:0]   m_addr;
    logic [N*32-1:0]   m_wdata;
    logic [N-1:0]      m_gnt;
    logic [N-1:0]      m_rvalid;
    logic [N-1:0]      m_err;
    logic [31:0]       m_rdata;
    logic              s_req;
    logic              s_we;
    logic [3:0]        s_be;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic              s_gnt;
    logic              s_rvalid;
    logic [31:0]       s_rdata;
    logic              stall;

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus per master
    bit          req_a   [N];
    bit          we_a    [N];
    logic [3:0]  be_a    [N];
    logic [31:0] addr_a  [N];
    logic [31:0] wdata_a [N];

    // Reference model state
    bit          mdl_busy;
    int          mdl_owner;
    int          mdl_last;
    logic [31:0] mdl_rsp;
    logic [31:0] mdl_mem [64];
    logic [N-1:0] exp_gnt;

    logic [31:0] slv_mem [64];

    always #5 clk = ~clk;

    gpio_bus_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_err    (m_err),
        .m_rdata  (m_rdata),
        .s_req    (s_req),
        .s_we     (s_we),
        .s_be     (s_be),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_gnt    (s_gnt),
        .s_rvalid (s_rvalid),
        .s_rdata  (s_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 5) ? 32'h0000_00A5 : (32'hC0DE_0000 | 32'(i));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    // GPIO register slave: 64 words at 0x000-0x0FC, grant unless stalled, response next cycle
    assign s_gnt = s_req && (s_addr[31:8] == 24'h0) && !stall;

    always @(posedge clk or negedge slv_rst_n) begin
        if (!slv_rst_n) begin
            s_rvalid <= 1'b0;
            s_rdata  <= 32'h0;
            for (int i = 0; i < 64; i++) slv_mem[i] <= init_word(i);
        end else begin
            s_rvalid <= s_req && s_gnt;
            s_rdata  <= (s_req && s_gnt) ? slv_mem[s_addr[7:2]] : 32'h0;
            if (s_req && s_gnt && s_we) slv_mem[s_addr[7:2]] <= merge(slv_mem[s_addr[7:2]], s_wdata, s_be);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic drive();
        for (int m = 0; m < N; m++) begin
            m_req[m]            = req_a[m];
            m_we[m]             = we_a[m];
            m_be[m*4 +: 4]      = be_a[m];
            m_addr[m*32 +: 32]  = addr_a[m];
            m_wdata[m*32 +: 32] = wdata_a[m];
        end
    endtask

    task automatic set_req(input int m, input bit r, input logic [31:0] a);
        req_a[m]   = r;
        we_a[m]    = 1'b0;
        be_a[m]    = 4'hF;
        addr_a[m]  = a;
        wdata_a[m] = 32'h0;
    endtask

    task automatic gen(input int m);
        req_a[m]   = ($urandom_range(0, 99) < 60);
        we_a[m]    = 1'($urandom_range(0, 1));
        be_a[m]    = 4'($urandom_range(0, 15));
        addr_a[m]  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        wdata_a[m] = $urandom;
    endtask

    // Next master in round-robin order after 'last' among requesters; -1 if none
    function automatic int pick(input logic [N-1:0] req, input int last);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        int             start;
        int             j_first;
        start   = (last + 1) % N;
        dbl     = {req, req};
        rot     = N'(dbl >> start);
        j_first = -1;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) j_first = j;
        end
        return (j_first < 0) ? -1 : (start + j_first) % N;
    endfunction

    task automatic mdl_reset();
        mdl_busy  = 1'b0;
        mdl_owner = 0;
        mdl_last  = N - 1;
        mdl_rsp   = 32'h0;
        exp_gnt   = '0;
    endtask

    // Predicts this cycle's outputs, compares them, then advances the model by one cycle
    task automatic model_cycle();
        int          w;
        bit          acc;
        bit          e_sreq;
        bit          e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [N-1:0] exp_rv;
        logic [31:0] exp_rd;
        #1;
        w      = pick(m_req, mdl_last);
        exp_rv = mdl_busy ? N'(1 << mdl_owner) : '0;
        exp_rd = mdl_busy ? mdl_rsp : 32'h0;
        if (w >= 0) begin
            e_sreq  = 1'b1;
            e_we    = we_a[w];
            e_be    = be_a[w];
            e_addr  = addr_a[w];
            e_wdata = wdata_a[w];
            acc     = !stall && (addr_a[w][31:8] == 24'h0);
        end else begin
            e_sreq  = 1'b0;
            e_we    = 1'b0;
            e_be    = 4'h0;
            e_addr  = 32'h0;
            e_wdata = 32'h0;
            acc     = 1'b0;
        end
        exp_gnt = acc ? N'(1 << w) : '0;
        chk("m_gnt",    32'(m_gnt),    32'(exp_gnt));
        chk("m_rvalid", 32'(m_rvalid), 32'(exp_rv));
        chk("m_rdata",  m_rdata,       exp_rd);
        chk("m_err",    32'(m_err),    32'h0);
        chk("s_req",    32'(s_req),    32'(e_sreq));
        chk("s_we",     32'(s_we),     32'(e_we));
        chk("s_be",     32'(s_be),     32'(e_be));
        chk("s_addr",   s_addr,        e_addr);
        chk("s_wdata",  s_wdata,       e_wdata);
        if (acc) begin
            mdl_busy  = 1'b1;
            mdl_owner = w;
            mdl_last  = w;
            mdl_rsp   = mdl_mem[e_addr[7:2]];
            if (e_we) mdl_mem[e_addr[7:2]] = merge(mdl_mem[e_addr[7:2]], e_wdata, e_be);
        end else begin
            mdl_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        for (int m = 0; m < N; m++) set_req(m, 1'b0, 32'h0);
        drive();
        stall = 1'b0;
        @(negedge clk);
        rst_n     = 1'b0;
        slv_rst_n = 1'b0;
        #1;
        chk("rst_gnt",    32'(m_gnt),    32'h0);
        chk("rst_rvalid", 32'(m_rvalid), 32'h0);
        chk("rst_err",    32'(m_err),    32'h0);
        chk("rst_rdata",  m_rdata,       32'h0);
        chk("rst_sreq",   32'(s_req),    32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        slv_rst_n = 1'b1;
        for (int i = 0; i < 64; i++) mdl_mem[i] = init_word(i);
        mdl_reset();
    endtask

    initial begin
        int stall_run;
        int gseen;
        int eseen;
        rst_n     = 1'b1;
        slv_rst_n = 1'b1;
        stall     = 1'b0;
        for (int m = 0; m < N; m++) set_req(m, 1'b0, 32'h0);
        drive();

        // Single read of GPIO_ODR
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 32'h14);
        drive();
        model_cycle();
        chk("single_gnt", 32'(m_gnt), 32'h1);
        @(negedge clk);
        set_req(0, 1'b0, 32'h0);
        drive();
        model_cycle();
        chk("single_rvalid", 32'(m_rvalid), 32'h1);
        chk("single_rdata",  m_rdata,       32'h0000_00A5);

        // Continuous contention between masters 0 and 1
        do_reset();
        set_req(0, 1'b1, 32'h20);
        set_req(1, 1'b1, 32'h24);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive();
            model_cycle();
            chk("rr_alternate", 32'(m_gnt), (c % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Slave stall: no grant while stalled, pointer frozen until the real grant
        do_reset();
        set_req(1, 1'b1, 32'h08);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive();
            model_cycle();
            chk("stall_nogrant", 32'(m_gnt), 32'h0);
        end
        @(negedge clk);
        stall = 1'b0;
        set_req(2, 1'b1, 32'h0C);
        drive();
        model_cycle();
        chk("stall_gnt", 32'(m_gnt), 32'h2);
        @(negedge clk);
        set_req(1, 1'b0, 32'h0);
        set_req(0, 1'b1, 32'h10);
        drive();
        model_cycle();
        chk("stall_rrptr", 32'(m_gnt), 32'h4);

        // Reset while waiting for a response; the late slave response must be dropped
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 32'h14);
        drive();
        model_cycle();
        chk("mid_rst_gnt", 32'(m_gnt), 32'h1);
        @(negedge clk);
        set_req(0, 1'b0, 32'h0);
        drive();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(m_rvalid), 32'h0);
        chk("mid_rst_rdata",  m_rdata,       32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("idle_rvalid_ignored", 32'(m_rvalid), 32'h0);
        chk("idle_rdata_ignored",  m_rdata,       32'h0);
        mdl_reset();
        @(negedge clk);
        set_req(0, 1'b1, 32'h18);
        set_req(1, 1'b1, 32'h1C);
        drive();
        model_cycle();
        chk("post_rst_first", 32'(m_gnt), 32'h1);

`ifdef GPIO_ARB_TIMEOUT_EN
        // Unmapped address: arbiter grants itself after TMO stalled cycles and answers with an error
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 32'h0000_0FFC);
        drive();
        for (int c = 0; c < TMO; c++) begin
            #1;
            chk("tmo_wait_gnt",  32'(m_gnt), 32'h0);
            chk("tmo_wait_sreq", 32'(s_req), 32'h1);
            @(negedge clk);
        end
        #1;
        chk("tmo_gnt",  32'(m_gnt), 32'h1);
        chk("tmo_sreq", 32'(s_req), 32'h0);
        @(negedge clk);
        set_req(0, 1'b0, 32'h0);
        drive();
        #1;
        chk("tmo_rvalid", 32'(m_rvalid), 32'h1);
        chk("tmo_err",    32'(m_err),    32'h1);
        chk("tmo_rdata",  m_rdata,       32'hDEAD_BEEF);
        @(negedge clk);
        #1;
        chk("tmo_done", 32'(m_rvalid), 32'h0);
`else
        // Unmapped address without timeout: the master stalls with no grant and no error
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 32'h0000_0FFC);
        drive();
        gseen = 0;
        eseen = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (m_gnt != '0) gseen++;
            if (m_err != '0) eseen++;
            @(negedge clk);
        end
        chk("notmo_grants", 32'(gseen), 32'h0);
        chk("notmo_errors", 32'(eseen), 32'h0);
`endif

        // Randomized traffic; masters hold requests until granted, stalls limited to two in a row
        do_reset();
        stall_run = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int m = 0; m < N; m++) begin
                if (!req_a[m] || exp_gnt[m]) gen(m);
            end
            stall     = (stall_run < 2) && ($urandom_range(0, 3) == 0);
            stall_run = stall ? stall_run + 1 : 0;
            drive();
            model_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
